// File: rtl/apb_arb_pkg.sv
`default_nettype none
// ============================================================================
// Package     : apb_arb_pkg
// Description : Shared types and constants for the APB request arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package apb_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } arb_state_e;

    localparam int c_tmo_cnt_w = 8;
    typedef logic [c_tmo_cnt_w-1:0] tmo_cnt_t;

    // Error flag reported to the requester when a transfer is aborted.
    localparam logic c_err_timeout = 1'b1;

endpackage
`default_nettype wire

// File: rtl/apb_req_arbiter_if.sv
`default_nettype none
// ============================================================================
// Interface   : apb_req_arbiter_if
// Description : Requester-side and APB-master-side signals of the arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface apb_req_arbiter_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_write;
    logic [NUM_REQ*32-1:0] req_addr;
    logic [NUM_REQ*32-1:0] req_wdata;
    logic [NUM_REQ-1:0]    req_ready;
    logic [NUM_REQ-1:0]    rsp_valid;
    logic [31:0]           rsp_rdata;
    logic                  rsp_err;

    logic                  m_treq;
    logic                  m_twrite;
    logic [31:0]           m_taddr;
    logic [31:0]           m_twdata;
    logic                  m_tdone;
    logic [31:0]           m_trdata;
    logic                  m_terr;
    logic                  m_tabort;

    // Environment side: requesters plus the downstream APB master.
    modport master (
        output req_valid, req_write, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
        input  m_treq, m_twrite, m_taddr, m_twdata, m_tabort,
        output m_tdone, m_trdata, m_terr
    );

    // Arbiter side.
    modport slave (
        input  req_valid, req_write, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
        output m_treq, m_twrite, m_taddr, m_twdata, m_tabort,
        input  m_tdone, m_trdata, m_terr
    );
endinterface
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational rotate-priority grant; search starts at ptr+1.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = $clog2(NUM_REQ)
) (
    input  wire [NUM_REQ-1:0] i_req,
    input  wire [PTR_W-1:0]   i_ptr,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [PTR_W-1:0]   o_idx,
    output logic               o_any
);
    int               w_pos;
    logic [PTR_W-1:0] w_sel;

    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        w_pos   = 0;
        w_sel   = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            w_pos = (int'(i_ptr) + i) % NUM_REQ;
            w_sel = PTR_W'(w_pos);
            if (!o_any && i_req[w_sel]) begin
                o_any          = 1'b1;
                o_grant[w_sel] = 1'b1;
                o_idx          = w_sel;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/apb_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : apb_req_arbiter
// Description : Round-robin arbiter funnelling NUM_REQ requesters onto one
//               APB master. Optional WAIT timeout: define APB_ARB_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module apb_req_arbiter
    import apb_arb_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int TIMEOUT_VAL = 16
) (
    input wire               s_axi_clk,
    input wire               s_axi_aresetn,
    apb_req_arbiter_if.slave bus
);
    localparam int PTR_W = $clog2(NUM_REQ);
    localparam logic [PTR_W-1:0] c_ptr_init = PTR_W'(NUM_REQ - 1);

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_VAL < 1 || TIMEOUT_VAL > 255) begin : g_param_check
        $error("apb_req_arbiter: NUM_REQ or TIMEOUT_VAL out of range");
    end

    arb_state_e         r_state;
    logic [PTR_W-1:0]   r_rr_ptr;
    logic [PTR_W-1:0]   r_owner;
    logic               r_write;
    logic [31:0]        r_addr;
    logic [31:0]        r_wdata;
    logic               r_treq;
    logic [NUM_REQ-1:0] r_rsp_valid;
    logic [31:0]        r_rsp_rdata;
    logic               r_rsp_err;

    logic [NUM_REQ-1:0] w_grant;
    logic [PTR_W-1:0]   w_grant_idx;
    logic               w_grant_any;
    logic [NUM_REQ-1:0] w_owner_oh;
    logic [31:0]        w_addr_arr  [NUM_REQ];
    logic [31:0]        w_wdata_arr [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign w_addr_arr[g]  = bus.req_addr[32*g +: 32];
        assign w_wdata_arr[g] = bus.req_wdata[32*g +: 32];
    end

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr_arbiter (
        .i_req   (bus.req_valid),
        .i_ptr   (r_rr_ptr),
        .o_grant (w_grant),
        .o_idx   (w_grant_idx),
        .o_any   (w_grant_any)
    );

    always_comb begin
        w_owner_oh          = '0;
        w_owner_oh[r_owner] = 1'b1;
    end

    // Acceptance is combinational and masked while reset is held.
    assign bus.req_ready = (r_state == ST_IDLE && s_axi_aresetn) ? w_grant : '0;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_rdata = r_rsp_rdata;
    assign bus.rsp_err   = r_rsp_err;
    assign bus.m_treq    = r_treq;
    assign bus.m_twrite  = r_write;
    assign bus.m_taddr   = r_addr;
    assign bus.m_twdata  = r_wdata;

`ifdef APB_ARB_TIMEOUT_EN
    tmo_cnt_t r_cnt;
    logic     r_tabort;
    assign bus.m_tabort = r_tabort;
`else
    assign bus.m_tabort = 1'b0;
`endif

    always_ff @(posedge s_axi_clk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            r_state     <= ST_IDLE;
            r_rr_ptr    <= c_ptr_init;
            r_owner     <= '0;
            r_write     <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_treq      <= 1'b0;
            r_rsp_valid <= '0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
`ifdef APB_ARB_TIMEOUT_EN
            r_cnt       <= '0;
            r_tabort    <= 1'b0;
`endif
        end else begin
            r_treq      <= 1'b0;
            r_rsp_valid <= '0;
`ifdef APB_ARB_TIMEOUT_EN
            r_tabort    <= 1'b0;
`endif
            case (r_state)
                ST_IDLE: begin
                    if (w_grant_any) begin
                        r_owner <= w_grant_idx;
                        r_write <= bus.req_write[w_grant_idx];
                        r_addr  <= w_addr_arr[w_grant_idx];
                        r_wdata <= w_wdata_arr[w_grant_idx];
                        r_treq  <= 1'b1;
                        r_state <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
`ifdef APB_ARB_TIMEOUT_EN
                    r_cnt   <= tmo_cnt_t'(TIMEOUT_VAL);
`endif
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    // A completion in the final counted cycle takes priority over the abort.
                    if (bus.m_tdone) begin
                        r_rsp_rdata <= r_write ? 32'h0 : bus.m_trdata;
                        r_rsp_err   <= bus.m_terr;
                        r_rsp_valid <= w_owner_oh;
                        r_state     <= ST_RESP;
                    end
`ifdef APB_ARB_TIMEOUT_EN
                    else if (r_cnt <= tmo_cnt_t'(1)) begin
                        r_cnt       <= '0;
                        r_tabort    <= 1'b1;
                        r_rsp_rdata <= 32'h0;
                        r_rsp_err   <= c_err_timeout;
                        r_rsp_valid <= w_owner_oh;
                        r_state     <= ST_RESP;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
`endif
                end
                ST_RESP: begin
                    r_rsp_rdata <= 32'h0;
                    r_rsp_err   <= 1'b0;
                    r_rr_ptr    <= r_owner;
                    r_state     <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_apb_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_apb_req_arbiter
// Description : Randomized self-checking bench with a transaction-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_apb_req_arbiter;
    localparam int N   = 4;
    localparam int TMO = 16;

    logic clk;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    // Model state: what each requester is asking for, and last served owner.
    logic [N-1:0] pend;
    logic         twr    [N];
    logic [31:0]  taddr  [N];
    logic [31:0]  twdata [N];
    int           last;

    apb_req_arbiter_if #(.NUM_REQ(N)) u_if ();

    apb_req_arbiter #(
        .NUM_REQ     (N),
        .TIMEOUT_VAL (TMO)
    ) dut (
        .s_axi_clk     (clk),
        .s_axi_aresetn (rst_n),
        .bus           (u_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic next_cycle();
        @(posedge clk);
        cyc++;
        #2;
    endtask

    task automatic drive();
        u_if.req_valid = pend;
        for (int i = 0; i < N; i++) begin
            u_if.req_write[i]          = twr[i];
            u_if.req_addr[32*i +: 32]  = taddr[i];
            u_if.req_wdata[32*i +: 32] = twdata[i];
        end
    endtask

    task automatic new_req(input int i);
        twr[i]    = 1'($urandom);
        taddr[i]  = $urandom;
        twdata[i] = $urandom;
        pend[i]   = 1'b1;
    endtask

    function automatic int rr_winner(input logic [N-1:0] p, input int l);
        for (int i = 1; i <= N; i++)
            if (p[(l + i) % N]) return (l + i) % N;
        return -1;
    endfunction

    function automatic int oh_idx(input logic [N-1:0] v);
        int r = -1;
        int n = 0;
        for (int i = 0; i < N; i++) if (v[i]) begin r = i; n++; end
        return (n == 1) ? r : -1;
    endfunction

    // One full transfer: grant now, completion on WAIT cycle d.
    task automatic run_txn(input int d, input logic [31:0] rdata, input logic err,
                           input bit drop, input bit add_others, output int owner);
        logic [N-1:0] exp_oh;
        logic         ew;
        logic [31:0]  ea, ed;
        owner = rr_winner(pend, last);
        #1;
        checks++;
        if (owner < 0) begin
            failures++;
            $display("FAIL grant_model: nothing pending, req_ready=%b", u_if.req_ready);
            return;
        end
        exp_oh = '0;
        exp_oh[owner] = 1'b1;
        if (u_if.req_ready !== exp_oh) begin
            failures++;
            $display("FAIL grant: req_ready=%b expected=%b", u_if.req_ready, exp_oh);
        end
        ew = twr[owner]; ea = taddr[owner]; ed = twdata[owner];
        u_if.m_tdone  = 1'($urandom);
        u_if.m_terr   = 1'($urandom);
        u_if.m_trdata = $urandom;
        next_cycle();
        checks++;
        if (u_if.m_treq !== 1'b1 || u_if.req_ready !== '0) begin
            failures++;
            $display("FAIL issue: m_treq=%b req_ready=%b expected 1/0", u_if.m_treq, u_if.req_ready);
        end
        checks++;
        if ({u_if.m_twrite, u_if.m_taddr, u_if.m_twdata} !== {ew, ea, ed}) begin
            failures++;
            $display("FAIL issue_fields: got %b %h %h expected %b %h %h",
                     u_if.m_twrite, u_if.m_taddr, u_if.m_twdata, ew, ea, ed);
        end
        if (drop) pend[owner] = 1'b0;
        else      new_req(owner);
        if (add_others)
            for (int i = 0; i < N; i++)
                if (i != owner && !pend[i] && ($urandom % 3 == 0)) new_req(i);
        drive();
        for (int k = 1; k <= d; k++) begin
            next_cycle();
            checks++;
            if ({u_if.m_treq, u_if.m_tabort, |u_if.rsp_valid, |u_if.req_ready} !== 4'b0) begin
                failures++;
                $display("FAIL wait_quiet: cycle %0d treq=%b tabort=%b rsp_valid=%b req_ready=%b expected all 0",
                         k, u_if.m_treq, u_if.m_tabort, u_if.rsp_valid, u_if.req_ready);
            end
            checks++;
            if ({u_if.m_twrite, u_if.m_taddr, u_if.m_twdata} !== {ew, ea, ed}) begin
                failures++;
                $display("FAIL wait_hold: got %h expected %h", u_if.m_taddr, ea);
            end
            u_if.m_tdone  = (k == d);
            u_if.m_trdata = (k == d) ? rdata : $urandom;
            u_if.m_terr   = (k == d) ? err : 1'($urandom);
        end
        next_cycle();
        checks++;
        if (u_if.rsp_valid !== exp_oh || u_if.rsp_err !== err || u_if.m_tabort !== 1'b0) begin
            failures++;
            $display("FAIL resp: rsp_valid=%b err=%b tabort=%b expected %b %b 0",
                     u_if.rsp_valid, u_if.rsp_err, u_if.m_tabort, exp_oh, err);
        end
        checks++;
        if (u_if.rsp_rdata !== (ew ? 32'h0 : rdata)) begin
            failures++;
            $display("FAIL resp_rdata: got %h expected %h", u_if.rsp_rdata, ew ? 32'h0 : rdata);
        end
        checks++;
        if ({u_if.m_twrite, u_if.m_taddr, u_if.m_twdata} !== {ew, ea, ed}) begin
            failures++;
            $display("FAIL resp_hold: got %h expected %h", u_if.m_taddr, ea);
        end
        u_if.m_tdone = 1'($urandom);
        last = owner;
        next_cycle();
        checks++;
        if (u_if.rsp_valid !== '0) begin
            failures++;
            $display("FAIL resp_pulse: rsp_valid=%b expected 0", u_if.rsp_valid);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        next_cycle();
        next_cycle();
        rst_n = 1'b1;
        last  = N - 1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        pend  = '0;
        for (int i = 0; i < N; i++) begin twr[i] = 1'b0; taddr[i] = '0; twdata[i] = '0; end
        drive();
        u_if.m_tdone = 1'b0; u_if.m_terr = 1'b0; u_if.m_trdata = '0;
        next_cycle();
        checks++;
        if ({u_if.req_ready, u_if.rsp_valid} !== '0) begin
            failures++;
            $display("FAIL reset_req: req_ready=%b rsp_valid=%b expected 0", u_if.req_ready, u_if.rsp_valid);
        end
        checks++;
        if ({u_if.rsp_err, u_if.rsp_rdata} !== 33'h0) begin
            failures++;
            $display("FAIL reset_rsp: err=%b rdata=%h expected 0", u_if.rsp_err, u_if.rsp_rdata);
        end
        checks++;
        if ({u_if.m_treq, u_if.m_twrite, u_if.m_taddr, u_if.m_twdata, u_if.m_tabort} !== 67'h0) begin
            failures++;
            $display("FAIL reset_master: treq=%b addr=%h wdata=%h tabort=%b expected 0",
                     u_if.m_treq, u_if.m_taddr, u_if.m_twdata, u_if.m_tabort);
        end
        pend = '1;
        drive();
        #1;
        checks++;
        if (u_if.req_ready !== '0) begin
            failures++;
            $display("FAIL reset_mask: req_ready=%b expected 0 during reset", u_if.req_ready);
        end
        pend = '0;
        drive();
        rst_n = 1'b1;
        last  = N - 1;
        next_cycle();
    endtask

    task automatic test_read_directed();
        int o;
        twr[1] = 1'b0; taddr[1] = 32'h10; twdata[1] = 32'h0; pend[1] = 1'b1;
        drive();
        run_txn(3, 32'hCAFE0001, 1'b0, 1'b1, 1'b0, o);
    endtask

    task automatic test_write_err();
        int o;
        twr[2] = 1'b1; taddr[2] = 32'h40; twdata[2] = 32'hA5A5A5A5; pend[2] = 1'b1;
        drive();
        run_txn(1, 32'hDEADBEEF, 1'b1, 1'b1, 1'b0, o);
    endtask

    task automatic test_late_done();
        int o;
        new_req(0);
        twr[0] = 1'b0;
        drive();
        run_txn(TMO, 32'h5EED0016, 1'b0, 1'b1, 1'b0, o);
    endtask

    // Slave never completes within the timeout window.
    task automatic test_long_wait();
        int           o;
        logic [N-1:0] exp_oh;
        new_req(3);
        twr[3] = 1'b0;
        drive();
        o = rr_winner(pend, last);
        exp_oh = '0;
        exp_oh[o] = 1'b1;
        #1;
        checks++;
        if (u_if.req_ready !== exp_oh) begin
            failures++;
            $display("FAIL long_grant: req_ready=%b expected=%b", u_if.req_ready, exp_oh);
        end
        next_cycle();
        pend[o] = 1'b0;
        drive();
`ifdef APB_ARB_TIMEOUT_EN
        for (int k = 1; k <= TMO; k++) begin
            next_cycle();
            u_if.m_tdone = 1'b0;
            checks++;
            if (u_if.m_tabort !== 1'b0 || u_if.rsp_valid !== '0) begin
                failures++;
                $display("FAIL tmo_early: wait cycle %0d tabort=%b rsp_valid=%b expected 0", k, u_if.m_tabort, u_if.rsp_valid);
            end
        end
        next_cycle();
        checks++;
        if (u_if.m_tabort !== 1'b1 || u_if.rsp_valid !== exp_oh || u_if.rsp_err !== 1'b1 || u_if.rsp_rdata !== 32'h0) begin
            failures++;
            $display("FAIL tmo_abort: tabort=%b rsp_valid=%b err=%b rdata=%h expected 1 %b 1 0",
                     u_if.m_tabort, u_if.rsp_valid, u_if.rsp_err, u_if.rsp_rdata, exp_oh);
        end
`else
        for (int k = 1; k <= 3 * TMO; k++) begin
            next_cycle();
            u_if.m_tdone = (k == 3 * TMO);
            u_if.m_trdata = 32'h0B0B0B0B;
            u_if.m_terr = 1'b0;
            checks++;
            if (u_if.m_tabort !== 1'b0 || u_if.rsp_valid !== '0) begin
                failures++;
                $display("FAIL unbounded: wait cycle %0d tabort=%b rsp_valid=%b expected 0", k, u_if.m_tabort, u_if.rsp_valid);
            end
        end
        next_cycle();
        checks++;
        if (u_if.rsp_valid !== exp_oh || u_if.rsp_rdata !== 32'h0B0B0B0B || u_if.m_tabort !== 1'b0) begin
            failures++;
            $display("FAIL unbounded_resp: rsp_valid=%b rdata=%h tabort=%b expected %b 0b0b0b0b 0",
                     u_if.rsp_valid, u_if.rsp_rdata, u_if.m_tabort, exp_oh);
        end
`endif
        u_if.m_tdone = 1'b0;
        last = o;
        next_cycle();
        checks++;
        if (u_if.m_tabort !== 1'b0 || u_if.rsp_valid !== '0) begin
            failures++;
            $display("FAIL long_after: tabort=%b rsp_valid=%b expected 0", u_if.m_tabort, u_if.rsp_valid);
        end
    endtask

    task automatic test_random();
        int o;
        int d;
        for (int t = 0; t < 30; t++) begin
            if (pend == '0) begin
                #1;
                checks++;
                if (u_if.req_ready !== '0) begin
                    failures++;
                    $display("FAIL idle: req_ready=%b expected 0", u_if.req_ready);
                end
                next_cycle();
                new_req(int'($urandom_range(0, N - 1)));
                drive();
            end
            d = ($urandom % 8 == 0) ? TMO : int'($urandom_range(1, 4));
            run_txn(d, $urandom, 1'($urandom), 1'($urandom), 1'b1, o);
        end
        pend = '0;
        drive();
    endtask

    task automatic test_back_to_back();
        int gq[$];
        int oq[$];
        int tq[$];
        int exp_order [5] = '{0, 1, 2, 3, 0};
        pend = '1;
        drive();
        u_if.m_tdone = 1'b1; u_if.m_terr = 1'b0; u_if.m_trdata = 32'h12345678;
        do_reset();
        for (int c = 0; c < 17; c++) begin
            #1;
            if (|u_if.req_ready) begin gq.push_back(c); oq.push_back(oh_idx(u_if.req_ready)); end
            if (u_if.m_treq) tq.push_back(c);
            next_cycle();
        end
        checks++;
        if (gq.size() != 5 || tq.size() != 4) begin
            failures++;
            $display("FAIL b2b_count: grants=%0d treqs=%0d expected 5/4", gq.size(), tq.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (gq[i] != 4 * i || oq[i] != exp_order[i]) begin
                    failures++;
                    $display("FAIL b2b_grant: #%0d cycle=%0d owner=%0d expected cycle=%0d owner=%0d",
                             i, gq[i], oq[i], 4 * i, exp_order[i]);
                end
            end
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (tq[i] != gq[i] + 1) begin
                    failures++;
                    $display("FAIL b2b_treq: #%0d m_treq cycle=%0d expected %0d", i, tq[i], gq[i] + 1);
                end
            end
        end
        pend = '0;
        drive();
        next_cycle();
        next_cycle();
        next_cycle();
        u_if.m_tdone = 1'b0;
        last = 0;
    endtask

    task automatic test_reset_mid();
        int o;
        new_req(0);
        drive();
        run_txn(1, $urandom, 1'b0, 1'b1, 1'b0, o);
        new_req(1);
        drive();
        u_if.m_tdone = 1'b0;
        #1;
        checks++;
        if (u_if.req_ready !== 4'b0010) begin
            failures++;
            $display("FAIL mid_grant: req_ready=%b expected 0010", u_if.req_ready);
        end
        next_cycle();
        next_cycle();
        pend = '1;
        drive();
        rst_n = 1'b0;
        #1;
        checks++;
        if ({u_if.req_ready, u_if.rsp_valid, u_if.rsp_err, u_if.rsp_rdata} !== '0) begin
            failures++;
            $display("FAIL mid_rst_rsp: req_ready=%b rsp_valid=%b err=%b rdata=%h expected 0",
                     u_if.req_ready, u_if.rsp_valid, u_if.rsp_err, u_if.rsp_rdata);
        end
        checks++;
        if ({u_if.m_treq, u_if.m_twrite, u_if.m_taddr, u_if.m_twdata, u_if.m_tabort} !== 67'h0) begin
            failures++;
            $display("FAIL mid_rst_master: treq=%b addr=%h wdata=%h tabort=%b expected 0",
                     u_if.m_treq, u_if.m_taddr, u_if.m_twdata, u_if.m_tabort);
        end
        next_cycle();
        checks++;
        if (u_if.rsp_valid !== '0 || u_if.m_tabort !== 1'b0) begin
            failures++;
            $display("FAIL mid_rst_hold: rsp_valid=%b tabort=%b expected 0", u_if.rsp_valid, u_if.m_tabort);
        end
        rst_n = 1'b1;
        last  = N - 1;
        #1;
        checks++;
        if (u_if.req_ready !== 4'b0001) begin
            failures++;
            $display("FAIL mid_first: req_ready=%b expected 0001", u_if.req_ready);
        end
        run_txn(2, $urandom, 1'b0, 1'b1, 1'b0, o);
    endtask

    initial begin
        test_reset();
        test_read_directed();
        test_write_err();
        test_late_done();
        test_long_wait();
        test_random();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
